// File: rtl/stream_mux_rr.sv
// stream_mux_rr: N-input registered stream multiplexer that picks a channel by fixed select or round-robin.
// Defining STREAM_MUX_COUNT_EN adds a saturating grant_count output of accepted transfers.
module stream_mux_rr #(
    parameter  int WIDTH = 16,
    parameter  int N     = 4,
    localparam int SW    = $clog2(N)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N*WIDTH-1:0] in_data,
    input  logic [N-1:0]       in_valid,
    output logic [N-1:0]       in_ready,
    input  logic               mode,
    input  logic [SW-1:0]      sel,
    output logic [WIDTH-1:0]   out_data,
    output logic [SW-1:0]      out_chan,
    output logic               out_valid,
    input  logic               out_ready
`ifdef STREAM_MUX_COUNT_EN
    ,
    output logic [15:0]        grant_count
`endif
);

    logic [SW-1:0]    ptr;
    logic             load;
    logic             sel_ok;
    logic             xfer;
    logic             grant_valid;
    logic [SW-1:0]    grant_idx;
    logic [WIDTH-1:0] grant_data;
    logic             rr_hi_found;
    logic             rr_lo_found;
    logic [SW-1:0]    rr_hi_idx;
    logic [SW-1:0]    rr_lo_idx;

    assign load   = ~out_valid | out_ready;
    assign sel_ok = 32'(sel) < N;

    // Round-robin: the lowest valid channel at or above ptr wins; otherwise wrap to the lowest valid overall.
    // NOTE: every signal written in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        rr_hi_found = 1'b0;
        rr_hi_idx   = '0;
        rr_lo_found = 1'b0;
        rr_lo_idx   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (in_valid[i]) begin
                rr_lo_found = 1'b1;
                rr_lo_idx   = SW'(i);
                if (i >= int'(ptr)) begin
                    rr_hi_found = 1'b1;
                    rr_hi_idx   = SW'(i);
                end
            end
        end
    end

    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        if (mode) begin
            grant_valid = rr_hi_found | rr_lo_found;
            grant_idx   = rr_hi_found ? rr_hi_idx : rr_lo_idx;
        end else if (sel_ok) begin
            grant_valid = in_valid[sel];
            grant_idx   = sel;
        end
    end

    assign xfer = grant_valid & load & ~reset;

    always_comb begin
        in_ready   = '0;
        grant_data = '0;
        for (int i = 0; i < N; i++) begin
            if (grant_idx == SW'(i)) begin
                in_ready[i] = xfer;
                grant_data  = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_chan  <= '0;
            ptr       <= '0;
        end else if (xfer) begin
            out_valid <= 1'b1;
            out_data  <= grant_data;
            out_chan  <= grant_idx;
            if (mode) begin
                ptr <= (grant_idx == SW'(N - 1)) ? '0 : grant_idx + SW'(1);
            end
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef STREAM_MUX_COUNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            grant_count <= '0;
        end else if (xfer && grant_count != 16'hFFFF) begin
            grant_count <= grant_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_stream_mux_rr.sv
// tb_stream_mux_rr: directed and randomized stimulus for stream_mux_rr, checked by a queue scoreboard
// fed from a behavioural model; the counter checks are active when STREAM_MUX_COUNT_EN is defined.
module tb_stream_mux_rr;

    localparam int WIDTH = 16;
    localparam int N     = 4;
    localparam int SW    = 2;

    typedef struct {
        logic [WIDTH-1:0] data;
        int               chan;
    } word_t;

    logic               clk = 1'b0;
    logic               reset;
    logic [N*WIDTH-1:0] in_data;
    logic [N-1:0]       in_valid;
    logic [N-1:0]       in_ready;
    logic               mode;
    logic [SW-1:0]      sel;
    logic [WIDTH-1:0]   out_data;
    logic [SW-1:0]      out_chan;
    logic               out_valid;
    logic               out_ready;
`ifdef STREAM_MUX_COUNT_EN
    logic [15:0]        grant_count;
`endif

    int    errors = 0;
    int    checks = 0;
    word_t sb[$];

    stream_mux_rr #(.WIDTH(WIDTH), .N(N)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .mode       (mode),
        .sel        (sel),
        .out_data   (out_data),
        .out_chan   (out_chan),
        .out_valid  (out_valid),
        .out_ready  (out_ready)
`ifdef STREAM_MUX_COUNT_EN
        ,
        .grant_count(grant_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ch(input int ch, input logic [WIDTH-1:0] val);
        in_data[ch*WIDTH +: WIDTH] = val;
    endtask

    // Reference grant: -1 means no channel is granted.
    function automatic int model_grant(input logic m, input int s, input logic [N-1:0] v, input int p);
        if (!m) return (s < N && v[s]) ? s : -1;
        for (int k = 0; k < N; k++) begin
            if (v[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    // Model: tracks occupancy, pointer and count; checks in_ready/out_valid and queues expected words.
    initial begin
        bit    m_full = 0;
        int    m_ptr  = 0;
        int    m_cnt  = 0;
        int    g;
        bit    ld;
        word_t w;
        forever begin
            @(negedge clk);
            if (reset) begin
                check("in_ready_in_reset", 32'(in_ready), 32'd0);
                m_full = 0;
                m_ptr  = 0;
                m_cnt  = 0;
                sb.delete();
            end else begin
                check("out_valid", 32'(out_valid), 32'(m_full));
`ifdef STREAM_MUX_COUNT_EN
                check("grant_count", 32'(grant_count), 32'(m_cnt));
`endif
                ld = !m_full || out_ready;
                g  = model_grant(mode, int'(sel), in_valid, m_ptr);
                check("in_ready", 32'(in_ready), (g >= 0 && ld) ? (32'd1 << g) : 32'd0);
                if (g >= 0 && ld) begin
                    w.data = in_data[g*WIDTH +: WIDTH];
                    w.chan = g;
                    sb.push_back(w);
                    if (mode) m_ptr = (g + 1) % N;
                    if (m_cnt < 65535) m_cnt++;
                    m_full = 1;
                end else if (out_ready) begin
                    m_full = 0;
                end
            end
        end
    end

    // Monitor: every consumed output word must match the oldest expected word.
    initial begin
        word_t w;
        forever begin
            @(negedge clk);
            if (!reset && out_valid === 1'b1 && out_ready) begin
                if (sb.size() == 0) begin
                    check("sb_underflow", 32'd1, 32'd0);
                end else begin
                    w = sb.pop_front();
                    check("out_data", 32'(out_data), 32'(w.data));
                    check("out_chan", 32'(out_chan), 32'(w.chan));
                end
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1);
    end

    initial begin
        int ch_seq[3] = '{0, 2, 3};

        // Reset with all channels valid.
        reset     = 1'b1;
        in_valid  = '1;
        mode      = 1'b0;
        sel       = 2'd2;
        out_ready = 1'b0;
        in_data   = {$urandom, $urandom};
        tick();
        tick();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_out_chan", 32'(out_chan), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        reset = 1'b0;
        #1;
        check("post_rst_in_ready", 32'(in_ready), 32'b0100);

        // Fixed select.
        set_ch(1, 16'd15);
        set_ch(0, 16'd10);
        sel       = 2'd1;
        out_ready = 1'b1;
        tick();
        check("fix_sel1_data", 32'(out_data), 32'd15);
        check("fix_sel1_chan", 32'(out_chan), 32'd1);
        sel = 2'd0;
        tick();
        check("fix_sel0_data", 32'(out_data), 32'd10);
        check("fix_sel0_chan", 32'(out_chan), 32'd0);

        // Round-robin over all channels, then with channel 1 idle.
        mode = 1'b1;
        for (int i = 0; i < N; i++) set_ch(i, 16'(16'hA0 + i));
        for (int k = 0; k < 8; k++) begin
            tick();
            check("rr_chan", 32'(out_chan), 32'(k % N));
            check("rr_data", 32'(out_data), 32'(16'hA0 + k % N));
        end
        in_valid = 4'b1101;
        for (int k = 0; k < 6; k++) begin
            tick();
            check("rr_skip_chan", 32'(out_chan), 32'(ch_seq[k % 3]));
        end

        // Backpressure then same-cycle refill.
        in_valid = '1;
        mode     = 1'b0;
        sel      = 2'd2;
        tick();
        check("bp_load_data", 32'(out_data), 32'h00A2);
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("bp_hold_valid", 32'(out_valid), 32'd1);
            check("bp_hold_data", 32'(out_data), 32'h00A2);
            check("bp_in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        sel       = 2'd3;
        #1;
        check("refill_in_ready", 32'(in_ready), 32'b1000);
        tick();
        check("refill_valid", 32'(out_valid), 32'd1);
        check("refill_data", 32'(out_data), 32'h00A3);

        // Reset mid-stream: a held word is dropped and ptr returns to 0.
        mode     = 1'b1;
        in_valid = 4'b0001;
        tick();
        check("pre_rst_chan", 32'(out_chan), 32'd0);
        reset     = 1'b1;
        out_ready = 1'b0;
        tick();
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        reset     = 1'b0;
        in_valid  = 4'b0011;
        out_ready = 1'b1;
        #1;
        check("mid_rst_in_ready", 32'(in_ready), 32'b0001);
        tick();
        check("mid_rst_chan", 32'(out_chan), 32'd0);

        // Randomized traffic with occasional resets.
        for (int k = 0; k < 3000; k++) begin
            reset     = ($urandom_range(0, 99) == 0);
            mode      = 1'($urandom);
            sel       = 2'($urandom);
            in_valid  = 4'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            in_data   = {$urandom, $urandom};
            tick();
        end
        reset = 1'b0;

`ifdef STREAM_MUX_COUNT_EN
        reset = 1'b1;
        tick();
        reset     = 1'b0;
        mode      = 1'b0;
        sel       = 2'd0;
        in_valid  = 4'b0001;
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) tick();
        check("count_5", 32'(grant_count), 32'd5);
        for (int k = 0; k < 65540; k++) tick();
        check("count_sat", 32'(grant_count), 32'hFFFF);
`endif

        // Drain: every expected word must have been consumed.
        in_valid  = '0;
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) tick();
        check("sb_empty", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
